// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  // Requester side
  logic [N_REQ-1:0]    req_i;
  logic [N_REQ-1:0]    ack_o;
  logic [N_REQ*AW-1:0] addr_i;
  logic [N_REQ*DW-1:0] wdata_i;
  logic [N_REQ-1:0]    we_i;
  logic [DW-1:0]       rdata_o;

  // Memory side
  logic                mem_req_o;
  logic                mem_ack_i;
  logic [AW-1:0]       mem_addr_o;
  logic [DW-1:0]       mem_wdata_o;
  logic                mem_we_o;
  logic [DW-1:0]       mem_rdata_i;

  // Status
  logic [N_REQ-1:0]    grant_o;
  logic                busy_o;

  // The arbiter itself
  modport slave (
    input  req_i, addr_i, wdata_i, we_i, mem_ack_i, mem_rdata_i,
    output ack_o, rdata_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o,
           grant_o, busy_o
  );

  // Whatever drives the requesters and models the memory
  modport master (
    output req_i, addr_i, wdata_i, we_i, mem_ack_i, mem_rdata_i,
    input  ack_o, rdata_o, mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o,
           grant_o, busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one four-phase memory port among N_REQ requesters
module mem_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MREQ,
    MREL,
    CACK
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic             pick_vld;
  logic [IW-1:0]    pick_idx;

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  // (base + off) mod N_REQ for off in 0..N_REQ
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IW-1:0];
  endfunction

  // Round-robin search: scanning offsets high to low lets the nearest request to ptr win
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[wrap_add(ptr_q, i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(ptr_q, i);
      end
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and registered-output next values
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    ack_d       = ack_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gidx_d      = pick_idx;
          grant_d     = ONE_HOT0 << pick_idx;
          mem_addr_d  = bus.addr_i[int'(pick_idx)*AW +: AW];
          mem_wdata_d = bus.wdata_i[int'(pick_idx)*DW +: DW];
          mem_we_d    = bus.we_i[pick_idx];
          mem_req_d   = 1'b1;
          state_d     = MREQ;
        end
      end
      MREQ: begin
        if (bus.mem_ack_i) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) rdata_d = bus.mem_rdata_i;
          state_d = MREL;
        end
      end
      MREL: begin
        if (!bus.mem_ack_i) begin
          ack_d   = ONE_HOT0 << gidx_q;
          state_d = CACK;
        end
      end
      CACK: begin
        // A requester that already dropped req gets a single-cycle ack here
        if (!bus.req_i[gidx_q]) begin
          ack_d   = '0;
          ptr_d   = wrap_add(gidx_q, 1);
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.grant_o     = grant_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized check of mem_arbiter against a transaction model
module tb_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Reference model: one transaction at a time, phases 0 idle, 1 memory asked,
  // 2 memory answered, 3 requester acknowledged
  int               m_phase, m_g, m_ptr, m_best;
  logic [N-1:0]     e_ack, e_grant;
  logic             e_mreq, e_we, e_busy;
  logic [AW-1:0]    e_addr;
  logic [DW-1:0]    e_wdata, e_rdata;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_g = 0;
      e_ack = '0; e_grant = '0; e_mreq = 0; e_we = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else begin
      case (m_phase)
        0: begin
          m_best = -1;
          for (int k = 0; k < N; k++)
            if (bus.req_i[k] && (m_best < 0 || (k - m_ptr + N) % N < (m_best - m_ptr + N) % N))
              m_best = k;
          if (m_best >= 0) begin
            m_g = m_best;
            e_grant = '0;
            e_grant[m_g] = 1'b1;
            e_addr  = bus.addr_i[m_g*AW +: AW];
            e_wdata = bus.wdata_i[m_g*DW +: DW];
            e_we    = bus.we_i[m_g];
            e_mreq  = 1'b1;
            m_phase = 1;
          end
        end
        1: if (bus.mem_ack_i) begin
          e_mreq = 1'b0;
          if (!e_we) e_rdata = bus.mem_rdata_i;
          m_phase = 2;
        end
        2: if (!bus.mem_ack_i) begin
          e_ack = '0;
          e_ack[m_g] = 1'b1;
          m_phase = 3;
        end
        default: if (!bus.req_i[m_g]) begin
          e_ack = '0;
          e_grant = '0;
          m_ptr = (m_g + 1) % N;
          m_phase = 0;
        end
      endcase
    end
    e_busy = (m_phase != 0);
  end

  // Every-cycle comparison of all registered outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack_o",       bus.ack_o,       e_ack);
      check("grant_o",     bus.grant_o,     e_grant);
      check("busy_o",      bus.busy_o,      e_busy);
      check("mem_req_o",   bus.mem_req_o,   e_mreq);
      check("mem_we_o",    bus.mem_we_o,    e_we);
      check("mem_addr_o",  bus.mem_addr_o,  e_addr);
      check("mem_wdata_o", bus.mem_wdata_o, e_wdata);
      check("rdata_o",     bus.rdata_o,     e_rdata);
    end
  end

  // Memory responder and requester agents
  int           mem_cnt, mem_dly, mem_dly_fixed;
  bit           mem_armed, mem_rd_rand;
  logic [DW-1:0] mem_rd_val;
  bit           auto_en, new_en, early_en, rst_en;
  int           rs[N];
  int           grants_seen = 0;
  logic [N-1:0] prev_grant = '0;

  task automatic mem_drive();
    if (rst) begin
      bus.mem_ack_i = 1'b0;
      mem_cnt = 0;
      mem_armed = 0;
    end else if (bus.mem_req_o && !bus.mem_ack_i) begin
      if (!mem_armed) begin
        mem_armed = 1;
        mem_cnt = 0;
        mem_dly = (mem_dly_fixed >= 0) ? mem_dly_fixed : int'($urandom_range(0, 3));
      end
      if (mem_cnt >= mem_dly) begin
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = mem_rd_rand ? DW'($urandom) : mem_rd_val;
      end else begin
        mem_cnt++;
      end
    end else if (!bus.mem_req_o && bus.mem_ack_i) begin
      bus.mem_ack_i = 1'b0;
      bus.mem_rdata_i = DW'($urandom);
      mem_armed = 0;
    end
  endtask

  task automatic req_drive();
    for (int k = 0; k < N; k++) begin
      case (rs[k])
        0: if (new_en && !bus.ack_o[k] && $urandom_range(0, 3) == 0) begin
          bus.req_i[k] = 1'b1;
          bus.addr_i[k*AW +: AW]  = AW'($urandom);
          bus.wdata_i[k*DW +: DW] = DW'($urandom);
          bus.we_i[k] = 1'($urandom_range(0, 1));
          rs[k] = 1;
        end
        1: if (bus.ack_o[k]) begin
          bus.req_i[k] = 1'b0;
          rs[k] = 2;
        end else if (early_en && bus.grant_o[k] && $urandom_range(0, 7) == 0) begin
          bus.req_i[k] = 1'b0;
          rs[k] = 3;
        end
        2: if (!bus.ack_o[k]) rs[k] = 0;
        default: if (bus.ack_o[k]) rs[k] = 2;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if ((bus.grant_o != '0) && (prev_grant == '0)) grants_seen++;
    prev_grant = bus.grant_o;
    mem_drive();
    if (auto_en) begin
      if (rst) rst = 1'b0;
      req_drive();
      if (rst_en && $urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        for (int k = 0; k < N; k++) if (rs[k] == 3) rs[k] = 0;
      end
    end
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    bus.addr_i[k*AW +: AW]  = a;
    bus.wdata_i[k*DW +: DW] = d;
    bus.we_i[k] = w;
    bus.req_i[k] = 1'b1;
  endtask

  task automatic finish_req(input int k, input string name);
    int n;
    n = 0;
    while (!bus.ack_o[k] && n < 40) begin tick(); n++; end
    if (!bus.ack_o[k]) fail(name);
    bus.req_i[k] = 1'b0;
    tick();
  endtask

  int got[$];

  task automatic serve_set(input logic [N-1:0] mask);
    int n;
    got.delete();
    for (int k = 0; k < N; k++) if (mask[k]) set_req(k, AW'(32'h100 + k), DW'(k), 1'b0);
    for (int t = 0; t < $countones(mask); t++) begin
      n = 0;
      while (bus.ack_o == '0 && n < 40) begin tick(); n++; end
      if (bus.ack_o == '0) begin fail("serve_set"); return; end
      for (int k = 0; k < N; k++) if (bus.ack_o[k]) begin got.push_back(k); bus.req_i[k] = 1'b0; end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi, n;
    bus.req_i = '0; bus.addr_i = '0; bus.wdata_i = '0; bus.we_i = '0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    mem_dly_fixed = 0; mem_rd_rand = 0; mem_rd_val = 32'hDEADBEEF;
    auto_en = 0; new_en = 0; early_en = 0; rst_en = 0;
    for (int k = 0; k < N; k++) rs[k] = 0;
    rst = 1'b1;
    tick(); tick();
    chk_en = 1;
    check("reset_ack", bus.ack_o, 4'b0000);
    check("reset_grant", bus.grant_o, 4'b0000);
    check("reset_busy", bus.busy_o, 1'b0);
    check("reset_rdata", bus.rdata_o, 32'h0);
    rst = 1'b0;

    // Single read from requester 2
    set_req(2, 32'h40, 32'h0, 1'b0);
    tick();
    check("rd_mem_req", bus.mem_req_o, 1'b1);
    check("rd_mem_addr", bus.mem_addr_o, 32'h40);
    check("rd_grant", bus.grant_o, 4'b0100);
    tick(); tick();
    check("rd_ack", bus.ack_o, 4'b0100);
    check("rd_rdata", bus.rdata_o, 32'hDEADBEEF);
    bus.req_i[2] = 1'b0;
    tick();
    check("rd_ack_fall", bus.ack_o, 4'b0000);

    // Single write from requester 0; memory drives junk that must not be captured
    mem_rd_val = 32'h0BADF00D;
    set_req(0, 32'h10, 32'h1234, 1'b1);
    tick();
    check("wr_we", bus.mem_we_o, 1'b1);
    check("wr_wdata", bus.mem_wdata_o, 32'h1234);
    check("wr_grant", bus.grant_o, 4'b0001);
    finish_req(0, "wr_ack");
    check("wr_rdata_kept", bus.rdata_o, 32'hDEADBEEF);

    // All four together from ptr=0, then 1 and 3
    rst = 1'b1; tick(); rst = 1'b0;
    serve_set(4'b1111);
    check("rr_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) check($sformatf("rr_all_%0d", i), got[i], i);
    serve_set(4'b1010);
    check("rr13_count", got.size(), 2);
    if (got.size() == 2) begin
      check("rr13_first", got[0], 1);
      check("rr13_second", got[1], 3);
    end

    // Slow memory: five-cycle acknowledge delay
    mem_dly_fixed = 5; mem_rd_val = 32'hCAFE0002;
    set_req(2, 32'h80, 32'h0, 1'b0);
    tick();
    n = 0;
    while (!bus.mem_ack_i && n < 30) begin
      check("slow_mem_req", bus.mem_req_o, 1'b1);
      check("slow_mem_addr", bus.mem_addr_o, 32'h80);
      check("slow_no_ack", bus.ack_o, 4'b0000);
      tick(); n++;
    end
    check("slow_delay_cycles", n, 5);
    finish_req(2, "slow_ack");
    check("slow_rdata", bus.rdata_o, 32'hCAFE0002);

    // Reset while requester 1 is in the release phase
    mem_dly_fixed = 0;
    set_req(1, 32'h55, 32'h0, 1'b0);
    tick(); tick();
    check("mrel_grant", bus.grant_o, 4'b0010);
    check("mrel_mem_req", bus.mem_req_o, 1'b0);
    rst = 1'b1; bus.req_i[1] = 1'b0;
    tick();
    rst = 1'b0;
    check("rstm_grant", bus.grant_o, 4'b0000);
    check("rstm_busy", bus.busy_o, 1'b0);
    check("rstm_addr", bus.mem_addr_o, 32'h0);
    check("rstm_rdata", bus.rdata_o, 32'h0);
    set_req(3, 32'h300, 32'h0, 1'b0);
    tick();
    check("post_rst_grant", bus.grant_o, 4'b1000);
    check("post_rst_addr", bus.mem_addr_o, 32'h300);
    finish_req(3, "post_rst_ack");

    // Requester 0 drops early; its ack pulses once, then requester 1 is next
    mem_dly_fixed = 2;
    set_req(0, 32'hA0, 32'h0, 1'b0);
    set_req(1, 32'hA1, 32'h0, 1'b0);
    tick();
    check("early_grant0", bus.grant_o, 4'b0001);
    bus.req_i[0] = 1'b0;
    hi = 0; n = 0;
    while (!bus.grant_o[1] && n < 30) begin
      tick(); n++;
      if (bus.ack_o[0]) hi++;
    end
    check("early_ack_pulse_len", hi, 1);
    check("early_next_grant", bus.grant_o, 4'b0010);
    finish_req(1, "early_r1_ack");

    // Randomized traffic with early drops and occasional resets
    mem_dly_fixed = -1; mem_rd_rand = 1;
    grants_seen = 0;
    auto_en = 1; new_en = 1; early_en = 1; rst_en = 1;
    for (int c = 0; c < 3000; c++) tick();
    new_en = 0; early_en = 0; rst_en = 0;
    n = 0;
    while (n < 300 && (bus.busy_o || rs[0] != 0 || rs[1] != 0 || rs[2] != 0 || rs[3] != 0 || rst)) begin
      tick(); n++;
    end
    if (n >= 300) fail("drain");
    check("rand_activity", grants_seen > 100, 1'b1);
    auto_en = 0;
    tick();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single memory port among N_REQ requesters. Each requester and the memory use the same four-phase req/ack handshake as the memory handshake controller. The arbiter grants one requester at a time in round-robin order, forwards its address, write data and write-enable on a registered memory-side handshake, and returns read data with an acknowledge. It sits between the processing elements and the memory controller, and is fully synchronous to one clock.

## Interface
- N_REQ, 4, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- clk_i  in  1  clock; all logic is on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- req_i  in  N_REQ  per-requester four-phase request
- ack_o  out  N_REQ  per-requester four-phase acknowledge
- addr_i  in  N_REQ*AW  requester addresses; slice k is [k*AW +: AW]
- wdata_i  in  N_REQ*DW  requester write data; slice k is [k*DW +: DW]
- we_i  in  N_REQ  requester write enables
- rdata_o  out  DW  read data of the last completed read
- mem_req_o  out  1  memory-side request
- mem_ack_i  in  1  memory-side acknowledge
- mem_addr_o  out  AW  latched address
- mem_wdata_o  out  DW  latched write data
- mem_we_o  out  1  latched write enable
- mem_rdata_i  in  DW  memory read data; valid while mem_ack_i=1
- grant_o  out  N_REQ  one-hot current grant; 0 in IDLE
- busy_o  out  1  1 whenever state is not IDLE

## Operation
- Every output is registered. Reset values:
  - ack_o, mem_req_o, mem_we_o, grant_o, busy_o = 0
  - mem_addr_o, mem_wdata_o, rdata_o = 0
  - round-robin pointer ptr = 0; state = IDLE
- FSM states: IDLE, MREQ, MREL, CACK.
- **IDLE**: if any req_i bit is 1, pick the first set bit searching ptr, ptr+1, … modulo N_REQ. On that edge:
  - latch g into grant_o
  - latch addr_i, wdata_i and we_i slice g onto the mem_* outputs
  - set mem_req_o=1 and go to MREQ
- **MREQ**: hold mem_req_o=1 until mem_ack_i is sampled 1. On that edge:
  - set mem_req_o=0
  - if mem_we_o=0, capture rdata_o=mem_rdata_i
  - go to MREL
- **MREL**: when mem_ack_i is sampled 0, set ack_o[g]=1 and go to CACK.
- **CACK**: when req_i[g] is sampled 0:
  - set ack_o[g]=0
  - set ptr = (g+1) mod N_REQ
  - clear grant_o and go to IDLE
- mem_addr_o, mem_wdata_o and mem_we_o stay stable from entry into MREQ until the next grant. rdata_o is stable from capture until the next read capture.
- Only ack_o[g] can be 1; all other ack_o bits stay 0.
- Requests from non-granted requesters are ignored until IDLE. They are never lost, because the four-phase protocol holds req_i high.

## Timing
- Round trip, with memory acknowledging in the cycle after mem_req_o and releasing in the cycle after mem_req_o falls:
  - edge 0: req_i seen, mem_req_o=1
  - edge 1: mem_ack_i seen
  - edge 2: mem_ack_i low seen, ack_o=1
- Minimum ack_o-fall to next grant: 1 cycle. IDLE always lasts at least one edge.
- Simultaneous requests: only round-robin order decides. A requester just served has the lowest priority next time.
- Protocol violation (req_i[g] drops before ack_o[g]): the memory transaction still completes. ack_o[g] then pulses for exactly one cycle, because req_i[g] is already 0 in CACK.
- mem_ack_i already 1 on entry to MREQ: accepted on the first MREQ edge.
- Reset mid-transaction: all outputs return to reset values on the next edge and ptr=0. The memory side must be reset by the same rst_i.
- Single requester with req_i held high across transactions: this cannot occur, because the requester must drop req_i to finish CACK.

## Test plan
- **Single read**: requester 2, addr=0x40, we=0, memory returns 0xDEADBEEF.
  - mem_addr_o=0x40, mem_req_o high 1 edge after req_i
  - ack_o=4'b0100 after mem_ack_i falls
  - rdata_o=0xDEADBEEF
- **Single write**: requester 0, addr=0x10, wdata=0x1234, we=1.
  - mem_we_o=1, mem_wdata_o=0x1234
  - rdata_o keeps its previous value
- **All four request together**: grants must go 0, 1, 2, 3.
  - Then with 1 and 3 requesting and ptr=0: grant 1 then 3.
- **Slow memory**: mem_ack_i delayed 5 cycles.
  - mem_req_o and mem_addr_o stay stable throughout
  - no ack_o until mem_ack_i falls
- **Reset in MREL** with requester 1 granted: next edge all outputs 0, busy_o=0, grant_o=0.
  - A following request from requester 3 is granted normally.
- **Early req drop**: requester 0 drops req_i during MREQ.
  - The transaction completes and ack_o[0] pulses for exactly one cycle
  - The next grant goes to requester 1 if it is requesting.
